// File: rtl/io_checkpoint_pkg.sv
// Shared types for the checkpoint-sequence monitor: FSM state encoding,
// step table entry layout and the masked compare used against each entry.
package io_checkpoint_pkg;

  // Width of the code/mask fields in a step entry; the monitor's CODE_W
  // parameter is expected to match it.
  localparam int unsigned CP_CODE_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } cp_state_t;

  typedef struct packed {
    logic [CP_CODE_W-1:0] code;
    logic [CP_CODE_W-1:0] mask;
  } step_entry_t;

  // A sample hits an entry when every masked-in bit equals the expected code.
  function automatic logic code_hit(input logic [CP_CODE_W-1:0] obs,
                                    input step_entry_t          ent);
    return ((obs ^ ent.code) & ent.mask) == '0;
  endfunction

endpackage

// File: rtl/io_checkpoint_sync.sv
// Two-flop synchronizer for a bus sampled from the pads. Bits are
// synchronized independently; the consumer deglitches multi-bit changes.
module io_checkpoint_sync #(
  parameter int unsigned W = 1
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  // two-stage capture of the asynchronous input
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/io_checkpoint_monitor.sv
// Checkpoint-sequence monitor: steps through a programmed list of expected
// codes on a synchronized pad field and reports pass/fail in hardware.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | after reset, nothing started
//   ST_RUN  | waiting for a stable match on the current step
//   ST_PASS | all len steps matched (sticky until start/reset)
//   ST_FAIL | timeout or strict-order violation (sticky until start/reset)
module io_checkpoint_monitor
  import io_checkpoint_pkg::*;
#(
  parameter int unsigned CODE_W        = CP_CODE_W,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned TIMEOUT_W     = 24
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [CODE_W-1:0]        obs_i,
  input  logic                     cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr_i,
  input  logic [CODE_W-1:0]        cfg_code_i,
  input  logic [CODE_W-1:0]        cfg_mask_i,
  input  logic [$clog2(DEPTH):0]   cfg_len_i,
  input  logic [TIMEOUT_W-1:0]     cfg_timeout_i,
  input  logic                     cfg_strict_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [$clog2(DEPTH):0]   step_o,
  output logic [CODE_W-1:0]        fail_code_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = AW + 1;
  localparam int unsigned HW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [HW-1:0] STABLE_TC = HW'(STABLE_CYCLES - 1);

  logic [CODE_W-1:0]    obs_s;
  logic [CODE_W-1:0]    obs_prev_q;
  logic [HW-1:0]        run_q, run_nxt;
  logic                 stable;

  step_entry_t          step_tbl [DEPTH];

  cp_state_t            state_q;
  logic [SW-1:0]        len_q, step_q, step_nxt, len_in;
  logic [TIMEOUT_W-1:0] tmo_lim_q, tmo_cnt_q;
  logic                 strict_q;
  logic [HW-1:0]        hit_cnt_q;
  logic                 timeout_q;
  logic [CODE_W-1:0]    fail_code_q;

  logic [AW-1:0]        step_idx, prev_idx;
  logic                 cur_hit, prev_hit, advance, tmo_hit, strict_hit;

  io_checkpoint_sync #(.W(CODE_W)) u_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .d        (obs_i),
    .q        (obs_s)
  );

  // Length of the current run of identical samples (minus one), saturating;
  // strict mode only trusts a wrong code once it has settled.
  assign run_nxt = (obs_s != obs_prev_q) ? '0 :
                   (run_q == STABLE_TC)  ? STABLE_TC : run_q + HW'(1);
  assign stable  = (run_nxt == STABLE_TC);

  // free-running stability tracker on the synchronized field
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      obs_prev_q <= '0;
      run_q      <= '0;
    end else begin
      obs_prev_q <= obs_s;
      run_q      <= run_nxt;
    end
  end

  // step table; frozen while a run is in progress, not cleared by reset
  always_ff @(posedge wb_clk_i) begin
    if (cfg_we_i && (state_q != ST_RUN))
      step_tbl[cfg_addr_i] <= '{code: cfg_code_i, mask: cfg_mask_i};
  end

  assign step_idx   = step_q[AW-1:0];
  assign prev_idx   = step_idx - AW'(1);
  assign step_nxt   = step_q + SW'(1);
  assign len_in     = (cfg_len_i > SW'(DEPTH)) ? SW'(DEPTH) : cfg_len_i;

  assign cur_hit    = code_hit(obs_s, step_tbl[step_idx]);
  assign prev_hit   = (step_q != '0) && code_hit(obs_s, step_tbl[prev_idx]);
  assign advance    = cur_hit && (hit_cnt_q == STABLE_TC);
  assign tmo_hit    = (tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q - TIMEOUT_W'(1));
  assign strict_hit = strict_q && !cur_hit && stable && !prev_hit;

  // run control: start/restart, step acceptance, timeout and strict failure
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      step_q      <= '0;
      tmo_lim_q   <= '0;
      tmo_cnt_q   <= '0;
      strict_q    <= 1'b0;
      hit_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
    end else if (start_i) begin
      step_q      <= '0;
      hit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      len_q       <= len_in;
      tmo_lim_q   <= cfg_timeout_i;
      strict_q    <= cfg_strict_i;
      state_q     <= (len_in == '0) ? ST_PASS : ST_RUN;
    end else if (state_q == ST_RUN) begin
      tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
      if (advance) begin
        step_q    <= step_nxt;
        hit_cnt_q <= '0;
        tmo_cnt_q <= '0;
        if (step_nxt == len_q)
          state_q <= ST_PASS;
      end else if (tmo_hit) begin
        state_q     <= ST_FAIL;
        timeout_q   <= 1'b1;
        fail_code_q <= obs_s;
      end else if (strict_hit) begin
        state_q     <= ST_FAIL;
        fail_code_q <= obs_s;
      end else if (cur_hit) begin
        hit_cnt_q <= hit_cnt_q + HW'(1);
      end else begin
        hit_cnt_q <= '0;
      end
    end
  end

  assign busy_o      = (state_q == ST_RUN);
  assign pass_o      = (state_q == ST_PASS);
  assign fail_o      = (state_q == ST_FAIL);
  assign timeout_o   = timeout_q;
  assign step_o      = step_q;
  assign fail_code_o = fail_code_q;

endmodule

// File: tb/tb_io_checkpoint_monitor.sv
// Bench for io_checkpoint_monitor: directed scenarios, a table of mask
// vectors and randomized runs, all checked every cycle against a
// window-based reference model.
module tb_io_checkpoint_monitor;

  localparam int STABLE = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic [5:0]  obs = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [5:0]  cfg_code = '0;
  logic [5:0]  cfg_mask = '0;
  logic [3:0]  cfg_len = '0;
  logic [23:0] cfg_timeout = '0;
  logic        cfg_strict = 1'b0;
  logic        start = 1'b0;
  logic        busy_o, pass_o, fail_o, timeout_o;
  logic [3:0]  step_o;
  logic [5:0]  fail_code_o;

  int    n_pass = 0;
  int    n_total = 0;
  string phase = "init";

  typedef struct {
    logic [5:0] code;
    logic [5:0] mask;
    logic [5:0] obs;
    logic       exp_pass;
    logic [3:0] exp_step;
  } mask_vec_t;
  mask_vec_t vecs[7];
  int mask_pick[4];

  // reference model state
  int m_code[8];
  int m_mask[8];
  bit m_busy, m_pass, m_fail, m_tflag, m_strict;
  int m_step, m_fcode, m_len, m_tmo, m_since;
  int drv_hist[$];
  int s_hist[$];

  io_checkpoint_monitor dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .obs_i         (obs),
    .cfg_we_i      (cfg_we),
    .cfg_addr_i    (cfg_addr),
    .cfg_code_i    (cfg_code),
    .cfg_mask_i    (cfg_mask),
    .cfg_len_i     (cfg_len),
    .cfg_timeout_i (cfg_timeout),
    .cfg_strict_i  (cfg_strict),
    .start_i       (start),
    .busy_o        (busy_o),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .timeout_o     (timeout_o),
    .step_o        (step_o),
    .fail_code_o   (fail_code_o)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h, expected %0h at %0t", phase, name, act, exp, $time);
  endtask

  function automatic bit m_match(input int os, input int idx);
    return ((os ^ m_code[idx]) & m_mask[idx]) == 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pass = 0; m_fail = 0; m_tflag = 0; m_strict = 0;
    m_step = 0; m_fcode = 0; m_len = 0; m_tmo = 0; m_since = 0;
    drv_hist.delete(); drv_hist.push_back(0); drv_hist.push_back(0);
    s_hist.delete(); s_hist.push_back(0);
  endtask

  // One clock edge of the specified behaviour, using the inputs as applied.
  task automatic model_step();
    int os;
    bit we_ok, all_match, all_same;
    we_ok = cfg_we && !m_busy;
    drv_hist.push_back(int'(obs));
    os = drv_hist[drv_hist.size()-3];
    if (drv_hist.size() > 3) void'(drv_hist.pop_front());
    s_hist.push_back(os);
    if (s_hist.size() > STABLE) void'(s_hist.pop_front());
    if (start) begin
      m_step = 0; m_tflag = 0; m_fcode = 0; m_since = 0;
      m_len = int'(cfg_len); m_tmo = int'(cfg_timeout); m_strict = cfg_strict;
      m_fail = 0; m_pass = (m_len == 0); m_busy = (m_len != 0);
    end else if (m_busy) begin
      m_since++;
      all_match = 1; all_same = (s_hist.size() == STABLE);
      foreach (s_hist[i]) begin
        if (!m_match(s_hist[i], m_step)) all_match = 0;
        if (s_hist[i] != os) all_same = 0;
      end
      if (m_since >= STABLE && all_match) begin
        m_step++; m_since = 0;
        if (m_step == m_len) begin m_busy = 0; m_pass = 1; end
      end else if (m_tmo != 0 && m_since == m_tmo) begin
        m_busy = 0; m_fail = 1; m_tflag = 1; m_fcode = os;
      end else if (m_strict && !m_match(os, m_step) && all_same &&
                   (m_step == 0 || !m_match(os, m_step - 1))) begin
        m_busy = 0; m_fail = 1; m_fcode = os;
      end
    end
    if (we_ok) begin
      m_code[cfg_addr] = int'(cfg_code);
      m_mask[cfg_addr] = int'(cfg_mask);
    end
  endtask

  task automatic check_all();
    chk("busy", busy_o, m_busy);
    chk("pass", pass_o, m_pass);
    chk("fail", fail_o, m_fail);
    chk("timeout", timeout_o, m_tflag);
    chk("step", step_o, m_step);
    chk("fail_code", fail_code_o, m_fcode);
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    model_step();
    @(negedge wb_clk_i);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", busy_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_fail", fail_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_step", step_o, 0);
    chk("rst_fail_code", fail_code_o, 0);
    #1 wb_rst_i = 1'b0;
  endtask

  task automatic prog(input int a, input int c, input int m);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_code = 6'(c); cfg_mask = 6'(m);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input int len, input int tmo, input bit strict);
    cfg_len = 4'(len); cfg_timeout = 24'(tmo); cfg_strict = strict; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic hold(input int v, input int n);
    obs = 6'(v);
    repeat (n) tick();
  endtask

  task automatic park();
    go(0, 0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{code: 6'h10, mask: 6'h30, obs: 6'h1F, exp_pass: 1'b1, exp_step: 4'd1};
    vecs[1] = '{code: 6'h10, mask: 6'h30, obs: 6'h2F, exp_pass: 1'b0, exp_step: 4'd0};
    vecs[2] = '{code: 6'h2A, mask: 6'h3F, obs: 6'h2A, exp_pass: 1'b1, exp_step: 4'd1};
    vecs[3] = '{code: 6'h2A, mask: 6'h3F, obs: 6'h2B, exp_pass: 1'b0, exp_step: 4'd0};
    vecs[4] = '{code: 6'h00, mask: 6'h00, obs: 6'h3F, exp_pass: 1'b1, exp_step: 4'd1};
    vecs[5] = '{code: 6'h3F, mask: 6'h01, obs: 6'h01, exp_pass: 1'b1, exp_step: 4'd1};
    vecs[6] = '{code: 6'h3F, mask: 6'h01, obs: 6'h3E, exp_pass: 1'b0, exp_step: 4'd0};
    mask_pick[0] = 63; mask_pick[1] = 3; mask_pick[2] = 1; mask_pick[3] = 60;

    phase = "reset";
    do_reset();

    phase = "basic";
    prog(0, 0, 63); prog(1, 1, 63); prog(2, 3, 63); prog(3, 2, 63);
    go(4, 0, 1'b0);
    chk("busy_after_start", busy_o, 1);
    hold(0, 6);
    chk("step_after_code0", step_o, 1);
    obs = 6'd1;
    tick(); tick(); tick();
    chk("latency_not_yet", step_o, 1);
    tick();
    chk("latency_advance", step_o, 2);
    hold(1, 2); hold(3, 6);
    chk("step_after_code3", step_o, 3);
    hold(2, 6);
    chk("basic_pass", pass_o, 1);
    chk("basic_busy", busy_o, 0);
    chk("basic_fail", fail_o, 0);
    chk("basic_step", step_o, 4);

    phase = "glitch";
    park(); prog(0, 0, 63); prog(1, 1, 63);
    go(2, 0, 1'b0);
    hold(0, 6);
    hold(1, 1); hold(0, 6);
    chk("glitch_step", step_o, 1);
    chk("glitch_fail", fail_o, 0);
    chk("glitch_busy", busy_o, 1);
    hold(1, 3); obs = 6'd0; tick();
    chk("held_step", step_o, 2);
    chk("held_pass", pass_o, 1);

    phase = "timeout";
    park(); prog(0, 0, 63);
    hold(7, 3);
    go(1, 100, 1'b0);
    repeat (99) tick();
    chk("tmo_not_early", fail_o, 0);
    tick();
    chk("tmo_fail", fail_o, 1);
    chk("tmo_flag", timeout_o, 1);
    chk("tmo_step", step_o, 0);
    chk("tmo_code", fail_code_o, 7);

    phase = "strict";
    park(); prog(0, 0, 63); prog(1, 1, 63);
    hold(0, 3);
    go(2, 0, 1'b1);
    hold(0, 6);
    chk("strict_prev_ok", busy_o, 1);
    hold(5, 4);
    chk("strict_fail", fail_o, 1);
    chk("strict_tflag", timeout_o, 0);
    chk("strict_code", fail_code_o, 5);
    chk("strict_step", step_o, 1);
    hold(0, 3);
    go(2, 0, 1'b0);
    hold(0, 6); hold(5, 10);
    chk("lax_busy", busy_o, 1);
    chk("lax_fail", fail_o, 0);

    phase = "mask_vec";
    foreach (vecs[i]) begin
      park();
      prog(0, int'(vecs[i].code), int'(vecs[i].mask));
      hold(int'(vecs[i].obs), 3);
      go(1, 0, 1'b0);
      hold(int'(vecs[i].obs), 6);
      chk("vec_pass", pass_o, vecs[i].exp_pass);
      chk("vec_step", step_o, vecs[i].exp_step);
      chk("vec_busy", busy_o, !vecs[i].exp_pass);
    end

    phase = "reset_mid_run";
    park(); prog(0, 0, 63); prog(1, 1, 63); prog(2, 3, 63); prog(3, 2, 63);
    go(4, 0, 1'b0);
    hold(0, 6); hold(1, 6);
    chk("at_step2", step_o, 2);
    do_reset();

    phase = "len_zero";
    go(0, 0, 1'b0);
    chk("len0_pass", pass_o, 1);
    chk("len0_busy", busy_o, 0);

    phase = "we_in_run";
    prog(0, 0, 63); prog(1, 1, 63);
    hold(0, 3);
    go(2, 0, 1'b0);
    prog(1, 5, 63);
    hold(0, 6); hold(1, 6);
    chk("we_dropped_pass", pass_o, 1);

    phase = "random";
    for (int r = 0; r < 40; r++) begin
      park();
      for (int a = 0; a < 8; a++)
        prog(a, int'($urandom_range(0, 3)), mask_pick[$urandom_range(0, 3)]);
      hold(int'($urandom_range(0, 3)), 2);
      go(int'($urandom_range(1, 8)),
         ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 40)),
         1'($urandom_range(0, 1)));
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 2) == 0) obs = 6'($urandom_range(0, 3));
        cfg_we = ($urandom_range(0, 29) == 0);
        cfg_addr = 3'($urandom_range(0, 7));
        cfg_code = 6'($urandom_range(0, 3));
        cfg_mask = 6'(mask_pick[$urandom_range(0, 3)]);
        start = ($urandom_range(0, 59) == 0);
        tick();
        cfg_we = 1'b0; start = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/io_checkpoint_monitor.md
# io_checkpoint_monitor

Synthesizable checkpoint-sequence monitor for the user project area. It watches a CODE_W-bit progress field driven on mprj_io by firmware and steps through a programmable list of up to DEPTH expected codes. Each step has a per-step mask, a deglitch requirement and an optional per-step timeout. Pass/fail is reported in hardware, so checkpoint checking no longer relies on testbench wait statements and works identically in RTL and GL.

## Interface
Parameters:
- CODE_W, 6: width of the observed checkpoint field.
- DEPTH, 8: maximum number of steps; power of two, at least 2.
- STABLE_CYCLES, 2: consecutive synchronized matching samples needed to accept a step; at least 1.
- TIMEOUT_W, 24: width of the per-step timeout counter.

Ports:
- wb_clk_i, in, 1: the single clock.
- wb_rst_i, in, 1: asynchronous, active-high reset.
- obs_i, in, CODE_W: observed pad field; asynchronous to wb_clk_i.
- cfg_we_i, in, 1: write step entry cfg_addr_i.
- cfg_addr_i, in, log2(DEPTH): step index.
- cfg_code_i, in, CODE_W: expected code.
- cfg_mask_i, in, CODE_W: compare mask; 1 = bit is compared.
- cfg_len_i, in, log2(DEPTH)+1: number of steps, 0..DEPTH; sampled at start.
- cfg_timeout_i, in, TIMEOUT_W: per-step cycle limit, 0 = disabled; sampled at start.
- cfg_strict_i, in, 1: strict ordering mode; sampled at start.
- start_i, in, 1: single-cycle start/restart pulse.
- busy_o, out, 1: run in progress.
- pass_o, out, 1: all steps matched; sticky.
- fail_o, out, 1: run failed; sticky.
- timeout_o, out, 1: the failure was a timeout.
- step_o, out, log2(DEPTH)+1: number of steps accepted so far.
- fail_code_o, out, CODE_W: synchronized code captured at failure.

## Operation
- obs_i passes through a 2-flop synchronizer to give obs_s. All comparisons use obs_s.
- Step table: DEPTH entries of {code, mask}, written when cfg_we_i=1 and the FSM is not in RUN. Writes during RUN are dropped. Table contents are undefined after reset and are not cleared by it.
- FSM states: IDLE, RUN, PASS, FAIL.
  - start_i in any state: clear step_o, hit_cnt, tmo_cnt, pass/fail/timeout and fail_code_o; latch len, timeout and strict. Go to PASS if len=0, else to RUN.
  - RUN, match: a match is ((obs_s ^ code[step]) & mask[step]) == 0. On a match, hit_cnt increments. When hit_cnt reaches STABLE_CYCLES-1 and matches again, step_o increments and hit_cnt and tmo_cnt clear. Reaching step_o=len moves the FSM to PASS.
  - RUN, non-match: hit_cnt clears.
  - RUN, strict mode: a non-match code held stable for STABLE_CYCLES samples that also fails the previous step's compare (step 0 has no previous step) causes FAIL, with fail_code_o set to obs_s.
  - RUN, timeout: tmo_cnt increments every RUN cycle. If timeout is nonzero and tmo_cnt reaches timeout-1 without an advance, go to FAIL with timeout_o=1 and fail_code_o=obs_s.
  - Same-cycle conflicts: an advance takes priority over both timeout and strict failure in the same cycle.
  - PASS and FAIL hold until the next start_i or reset.
- Outputs: busy_o=(state==RUN), pass_o=(state==PASS), fail_o=(state==FAIL).

## Timing
- Reset (asynchronous): state IDLE; all outputs 0; step_o=0; fail_code_o=0; synchronizer flops 0.
- All outputs are registered.
- start_i at edge s: busy_o (or pass_o when len=0) is 1 after edge s.
- Advance latency: let edge n be the first edge at which obs_i holds the matching value. If obs_i stays matching through edge n+STABLE_CYCLES, step_o increments after edge n+STABLE_CYCLES+1. With the default, that is after edge n+3.
- Glitches: a matching value shorter than STABLE_CYCLES samples never advances the step.
- Timeout: fail_o rises exactly `timeout` cycles after the later of start or the last advance.
- The final advance and pass_o assert on the same edge.
- Reset asserted mid-run: aborts immediately with no partial result.
- start_i during RUN: restarts cleanly on that edge.

## Structure
- Package io_checkpoint_pkg holds the state enum (IDLE/RUN/PASS/FAIL) and a step_entry_t struct {code, mask}.
- Sub-module io_checkpoint_sync: a parametrised-width 2-flop synchronizer with asynchronous reset.
- The step table is a flop array; no SRAM macro.

## Test plan
All scenarios use default parameters.
- Program steps {0,1,3,2} with mask 0x3F, len=4, timeout=0. Drive each code for 6 cycles → step_o goes 1,2,3,4, pass_o=1, busy_o=0, fail_o=0.
- Drive a 1-cycle pulse of the expected code 1, then return to 0 → step_o does not advance, no fail. Holding the code for 3 cycles then advances it.
- Set timeout=100 and hold obs_i=7 with step 0 expecting 0 → fail_o=1, timeout_o=1, step_o=0, fail_code_o=7, exactly 100 cycles after start.
- Strict mode, steps {0,1}: after step 0 is accepted, hold obs=5 → fail_o=1, timeout_o=0, fail_code_o=5, step_o=1. With strict off, the same stimulus keeps busy_o=1.
- Step 0 code=0x10, mask=0x30; drive obs=0x1F → advance; drive obs=0x2F → no advance.
- Assert wb_rst_i at step 2 → all outputs 0 immediately. Start with len=0 → pass_o=1 one cycle later. cfg_we_i during RUN leaves the table unchanged, checked by the subsequent run.
